// File: rtl/axis_byte_packetizer_pkg.sv
// Shared configuration for the byte packetizer: default packet width, derived byte count and packet type.
// Imported by the packetizer top; the PACKETIZER_TIMEOUT_EN build needs no extra package content.
package axis_byte_packetizer_pkg;

   localparam int INP_WIDTH = 16;
   localparam int INP_BYTES = (INP_WIDTH + 7) / 8;

   typedef logic [INP_WIDTH-1:0] inp_pkt_t;

   // Byte-index counter width; a single-byte packet still needs a 1-bit index.
   function automatic int idx_bits(input int bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/axis_byte_packetizer_if.sv
// Minimal AXI-Stream bundle (tdata/tvalid/tready) with master and slave views.
// Used for both the 8-bit byte input and the INP_WIDTH-bit packet output.
interface axis_byte_packetizer_if #(
   parameter int W = 8
) ();
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_byte_packetizer.sv
// Assembles an MSB-first byte stream into INP_WIDTH-bit packets with a one-packet output buffer.
// Optional macro PACKETIZER_TIMEOUT_EN adds an inter-byte gap timeout and a drop_count port.
module axis_byte_packetizer
   import axis_byte_packetizer_pkg::*;
#(
   parameter int INP_WIDTH      = axis_byte_packetizer_pkg::INP_WIDTH,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   axis_byte_packetizer_if.slave  s_axis,
   axis_byte_packetizer_if.master m_axis,
`ifdef PACKETIZER_TIMEOUT_EN
   output logic [15:0]           drop_count,
`endif
   output logic                  partial
);

   localparam int INP_BYTES = (INP_WIDTH + 7) / 8;
   localparam int SW        = 8 * INP_BYTES;
   localparam int IW        = idx_bits(INP_BYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(INP_BYTES - 1);

   logic [IW-1:0]        byte_idx_q, byte_idx_d;
   logic [SW-1:0]        shift_q, shift_d;
   logic [INP_WIDTH-1:0] m_data_q, m_data_d;
   logic                 m_valid_q, m_valid_d;
   logic [SW-1:0]        byte_ext, word;
   logic                 s_ready, byte_hs, pkt_hs;

`ifdef PACKETIZER_TIMEOUT_EN
   logic [31:0]          gap_q, gap_d;
   logic [15:0]          drop_q, drop_d;
`endif

   // Only the final byte can stall, and only when the buffered packet is not leaving.
   assign s_ready       = (byte_idx_q != LAST_IDX) || !m_valid_q || m_axis.tready;
   assign s_axis.tready = s_ready;
   assign m_axis.tdata  = m_data_q;
   assign m_axis.tvalid = m_valid_q;
   assign partial       = (byte_idx_q != '0);
`ifdef PACKETIZER_TIMEOUT_EN
   assign drop_count    = drop_q;
`endif

   // Shifting the holding register left by one byte keeps earlier bytes more significant;
   // truncation to INP_WIDTH discards the surplus high bits of the first byte.
   always_comb begin
      byte_ext      = '0;
      byte_ext[7:0] = s_axis.tdata;
      word          = (shift_q << 8) | byte_ext;
   end

   always_comb begin
      byte_hs    = s_axis.tvalid && s_ready;
      pkt_hs     = m_valid_q && m_axis.tready;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      m_data_d   = m_data_q;
      m_valid_d  = m_valid_q;

      if (pkt_hs) begin
         m_valid_d = 1'b0;
      end

      if (byte_hs) begin
         if (byte_idx_q == LAST_IDX) begin
            m_data_d   = word[INP_WIDTH-1:0];
            m_valid_d  = 1'b1;
            byte_idx_d = '0;
            shift_d    = '0;
         end else begin
            shift_d    = word;
            byte_idx_d = byte_idx_q + IW'(1);
         end
      end

`ifdef PACKETIZER_TIMEOUT_EN
      gap_d  = gap_q;
      drop_d = drop_q;
      // An arriving byte always beats the timeout in the same cycle.
      if (byte_hs) begin
         gap_d = '0;
      end else if (byte_idx_q != '0) begin
         if (gap_q == 32'(TIMEOUT_CYCLES - 1)) begin
            gap_d      = '0;
            byte_idx_d = '0;
            shift_d    = '0;
            if (drop_q != 16'hFFFF) begin
               drop_d = drop_q + 16'd1;
            end
         end else begin
            gap_d = gap_q + 32'd1;
         end
      end else begin
         gap_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx_q <= '0;
         shift_q    <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
`ifdef PACKETIZER_TIMEOUT_EN
         gap_q      <= '0;
         drop_q     <= '0;
`endif
      end else begin
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
`ifdef PACKETIZER_TIMEOUT_EN
         gap_q      <= gap_d;
         drop_q     <= drop_d;
`endif
      end
   end

endmodule

// File: doc/axis_byte_packetizer.md
Name: axis_byte_packetizer

Overview:
Upstream neighbour of the AXIS processor wrapper. Accepts an 8-bit AXI-Stream byte stream (UART/host side) and assembles big-endian INP_WIDTH-bit input packets. Presents each packet on an AXIS master that connects directly to the processor's s_axis port. Provides one-packet output buffering and full-rate throughput with no bubbles.

Parameters:
- INP_WIDTH, processor_config::INP_WIDTH: output packet width in bits; legal range 1..64.
- INP_BYTES, (INP_WIDTH+7)/8: bytes per packet. Derived; must not be overridden.
- TIMEOUT_CYCLES, 1000000: inter-byte gap, in clk cycles, that aborts a partial packet. Used only with the optional feature; legal range ≥2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8  incoming byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted this cycle when high together with tvalid.
- m_axis_tdata  out  INP_WIDTH  assembled packet.
- m_axis_tvalid  out  1  packet valid.
- m_axis_tready  in  1  downstream (processor) accepts the packet.
- partial  out  1  high while 1..INP_BYTES-1 bytes of a packet are held.

Behaviour:
- Reset: the following all go to 0 on the first clk edge with rst=1:
  - m_axis_tvalid, m_axis_tdata, partial, the shift register and byte_idx.
  - drop_count (feature only).
  - s_axis_tready may be high during reset; bytes presented during reset are ignored.
- A byte handshake is s_axis_tvalid && s_axis_tready at a rising edge. A packet handshake is m_axis_tvalid && m_axis_tready.
- Byte order is MSB-first:
  - The first byte received fills the most significant byte.
  - For INP_WIDTH not a multiple of 8, the upper 8*INP_BYTES-INP_WIDTH bits of the first byte are discarded.
  - Example: INP_WIDTH=16, bytes 0x84 then 0x60 give packet 0x8460.
- byte_idx counts 0..INP_BYTES-1.
  - Bytes with byte_idx < INP_BYTES-1 shift into the holding register, and byte_idx increments.
  - The last byte (byte_idx == INP_BYTES-1) is written straight into m_axis_tdata as {holding, byte}. byte_idx returns to 0 and m_axis_tvalid is set.
- s_axis_tready = (byte_idx != INP_BYTES-1) || !m_axis_tvalid || m_axis_tready.
  - Non-final bytes are never stalled.
  - The final byte stalls only while the output buffer is full and not draining.
- Latency: m_axis_tvalid rises 1 cycle after the final byte handshake.
- Throughput: one packet per INP_BYTES cycles sustained when m_axis_tready=1.
- Output hold: while m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tvalid are stable.
  - m_axis_tvalid clears the cycle after a packet handshake, unless a final byte is accepted in that same cycle. In that case tvalid stays high and tdata takes the new packet, with no bubble.
- INP_BYTES==1: each byte is a registered pass-through (masked to INP_WIDTH), and s_axis_tready = !m_axis_tvalid || m_axis_tready.
- partial = (byte_idx != 0).
- Reset mid-packet: the partial packet and any buffered output packet are discarded with no output. The next byte received after reset is treated as byte 0.

Optional Feature:
Macro: PACKETIZER_TIMEOUT_EN.

With the macro defined:
- A gap counter clears on every byte handshake and increments while partial=1.
- When it reaches TIMEOUT_CYCLES-1, byte_idx and the holding register clear (the partial packet is dropped).
- drop_count increments, saturating at 0xFFFF.
- Adds output port drop_count, out, 16 bits, reset 0.
- A byte handshake in the same cycle as the timeout wins: that byte is kept and the timeout is ignored.
- This resynchronises framing after host glitches.

Without the macro: there is no gap counter and no drop_count port, and partial packets wait indefinitely.

Decomposition:
- Add to processor_config: localparam INP_BYTES = (INP_WIDTH+7)/8, and typedef logic [INP_WIDTH-1:0] inp_pkt_t.
- No sub-module is needed. With the feature, the gap counter is inline logic inside `ifdef.
- The top-level integration instantiates axis_byte_packetizer feeding axis_processor.

Test Plan:
- Single packet, INP_WIDTH=16: bytes 0x84, 0x60 with m_axis_tready=1 → one packet 0x8460; tvalid high exactly 1 cycle, starting 1 cycle after byte 0x60.
- Streaming: bytes 84 60 20 01 94 40 20 31 sent back-to-back → packets 0x8460, 0x2001, 0x9440, 0x2031, one every 2 cycles, s_axis_tready constant 1.
- Backpressure: hold m_axis_tready=0 after the first packet.
  - s_axis_tready drops only when the 4th byte is presented; the first packet is held stable.
  - Releasing tready drains 0x8460 then 0x2001 with no loss or duplication.
- Reset mid-packet: send 0x84, assert rst for 1 cycle, then send 0x20, 0x01 → only packet 0x2001 is output; partial=0 after reset.
- Simultaneous events: with m_axis_tvalid=1, assert m_axis_tready in the same cycle the final byte arrives → tvalid stays high and tdata updates to the new packet the next cycle.
- PACKETIZER_TIMEOUT_EN, TIMEOUT_CYCLES=10: send 0x84, idle 12 cycles, then send 0x20, 0x01 → output 0x2001 only, drop_count=1.
